mem_stage: RTL and testbench

- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives a multi-cycle data memory over a req/ack handshake for LW/SW.
- Produces the MEM/WB register for writeback and a forwarding tap for the execute stage.
- Stalls upstream while a memory access is outstanding, and aborts accesses that time out.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_dmem_handshake.sv | 69 ++++++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared opcode header for the execute and memory stages, plus datapath widths.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int OP_W   = 4;
  localparam int REG_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0101;
  localparam logic [OP_W-1:0] OP_LW  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW  = 4'b1001;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// IDLE/WAIT handshake controller: owns the request, the timeout counter and
// the strobes telling the memory stage when its held instruction leaves.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic m_valid,
  input  logic is_mem,
  input  logic accept_mem,
  input  logic ack,
  output logic req,
  output logic acked,
  output logic timeout_hit,
  output logic complete,
  output logic advance
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;

  assign req         = (state == WAIT);
  assign acked       = req & ack;
  assign timeout_hit = req & ~ack & (count == LAST_CNT);
  assign complete    = m_valid & (~is_mem | acked);
  assign advance     = complete | timeout_hit;

  // Request FSM and wait counter; a new memory op accepted on the ack edge keeps the request up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_valid && is_mem) begin
            state <= WAIT;
            count <= '0;
          end
        end
        WAIT: begin
          if (ack) begin
            state <= accept_mem ? WAIT : IDLE;
            count <= '0;
          end else if (timeout_hit) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, LW/SW data-memory access, MEM/WB register
// and the EX/MEM forwarding tap for the execute stage.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_opcode,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  output logic              mem_ready,
  mem_stage_if.master       dmem,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_halt,
  output logic              mem_err
);

  logic              m_valid;
  logic [OP_W-1:0]   m_opcode;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [REG_W-1:0]  m_rd;
  logic              m_regwrite;

  logic is_mem;
  logic accept;
  logic accept_mem;
  logic req;
  logic acked;
  logic timeout_hit;
  logic complete;
  logic advance;
  logic addr_lsb_unused;

  assign is_mem     = is_mem_op(m_opcode);
  assign mem_ready  = ~m_valid | ~is_mem | acked | timeout_hit;
  assign accept     = ex_valid & mem_ready;
  assign accept_mem = accept & is_mem_op(ex_opcode);

  dmem_handshake #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_handshake (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .is_mem      (is_mem),
    .accept_mem  (accept_mem),
    .ack         (dmem.dmem_ack),
    .req         (req),
    .acked       (acked),
    .timeout_hit (timeout_hit),
    .complete    (complete),
    .advance     (advance)
  );

  // Memory bus: word-aligned address, fields only driven while a request is up.
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & (m_opcode == OP_SW);
  assign dmem.dmem_addr  = req ? {m_addr[ADDR_W-1:1], 1'b0} : '0;
  assign dmem.dmem_wdata = req ? m_data : '0;
  assign addr_lsb_unused = m_addr[0];

  // A loaded value is not known until the ack, so only non-LW results forward.
  assign fwd_valid = m_valid & m_regwrite & (m_opcode != OP_LW);
  assign fwd_rd    = m_rd;
  assign fwd_data  = m_data;

  // EX/MEM register: capture on accept, empty when the held instruction leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_opcode   <= '0;
      m_addr     <= '0;
      m_data     <= '0;
      m_rd       <= '0;
      m_regwrite <= 1'b0;
    end else if (accept) begin
      m_valid    <= 1'b1;
      m_opcode   <= ex_opcode;
      m_addr     <= ex_addr;
      m_data     <= ex_data;
      m_rd       <= ex_rd;
      m_regwrite <= ex_regwrite;
    end else if (advance) begin
      m_valid    <= 1'b0;
    end
  end

  // MEM/WB register: a timed-out access never reaches writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_halt  <= 1'b0;
    end else begin
      wb_valid <= complete;
      wb_we    <= complete & m_regwrite & (m_opcode != OP_SW);
      wb_halt  <= complete & (m_opcode == OP_HLT);
      wb_rd    <= m_rd;
      wb_data  <= (m_opcode == OP_LW) ? dmem.dmem_rdata : m_data;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model of the stage plus directed vectors.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        rw;
    int          lat;    // ack on this WAIT cycle (1-based); 0 = never ack
    logic [15:0] rdata;
  } ins_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] d;
    logic        we;
    logic        halt;
  } wbe_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = '0;
  logic [15:0] ex_addr = '0;
  logic [15:0] ex_data = '0;
  logic [3:0]  ex_rd = '0;
  logic        ex_regwrite = 1'b0;
  logic        mem_ready;
  logic        fwd_valid;
  logic [3:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        wb_valid;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_halt;
  logic        mem_err;

  mem_stage_if bus ();

  mem_stage #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_opcode   (ex_opcode),
    .ex_addr     (ex_addr),
    .ex_data     (ex_data),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .mem_ready   (mem_ready),
    .dmem        (bus),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_halt     (wb_halt),
    .mem_err     (mem_err)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit go = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- model: one held instruction, a request window, sticky error
  ins_t        cur;
  bit          hv = 0;
  ins_t        h;
  bit          reqing = 0;
  int          rc = 0;
  bit          err = 0;
  bit          m_acc = 0;
  bit          e_wbv = 0, e_wbwe = 0, e_halt = 0;
  logic [3:0]  e_rd = '0;
  logic [15:0] e_data = '0;

  function automatic bit mdl_is_mem();
    return hv && (h.op == OP_LW || h.op == OP_SW);
  endfunction
  function automatic bit mdl_acked();
    return reqing && (bus.dmem_ack === 1'b1);
  endfunction
  function automatic bit mdl_to();
    return reqing && (bus.dmem_ack !== 1'b1) && (rc == TO - 1);
  endfunction
  function automatic bit mdl_ready();
    return !hv || !mdl_is_mem() || mdl_acked() || mdl_to();
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hv = 0; reqing = 0; rc = 0; err = 0; m_acc = 0;
      e_wbv = 0; e_wbwe = 0; e_halt = 0; e_rd = '0; e_data = '0;
    end else begin
      bit ack_q, to_q, rdy, done;
      ack_q = mdl_acked();
      to_q  = mdl_to();
      rdy   = mdl_ready();
      done  = hv && (!mdl_is_mem() || ack_q);
      e_wbv  = done;
      e_wbwe = done && h.rw && (h.op != OP_SW);
      e_halt = done && (h.op == OP_HLT);
      e_rd   = h.rd;
      e_data = (h.op == OP_LW) ? bus.dmem_rdata : h.data;
      if (to_q) err = 1;
      m_acc = ex_valid && rdy;
      if (m_acc) begin
        reqing = ack_q && (ex_opcode == OP_LW || ex_opcode == OP_SW);
        h = '{ex_opcode, ex_addr, ex_data, ex_rd, ex_regwrite, cur.lat, cur.rdata};
        hv = 1;
        rc = 0;
      end else if (rdy) begin
        hv = 0; reqing = 0; rc = 0;
      end else if (reqing) begin
        rc++;
      end else if (mdl_is_mem()) begin
        reqing = 1; rc = 0;
      end
    end
  end

  // Memory responder: ack per instruction latency; stray acks whenever no request is expected.
  always begin
    @(posedge clk);
    #1;
    if (reqing && h.lat != 0 && rc + 1 == h.lat) begin
      bus.dmem_ack = 1'b1; bus.dmem_rdata = h.rdata;
    end else if (!reqing) begin
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 16'hDEAD;
    end else begin
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 16'h0000;
    end
  end

  // ---------------- per-cycle compare
  wbe_t lg[$];
  int   lgc[$];
  int   cyc = 0;
  int   to_req_cycles = 0;

  always @(negedge clk) begin
    if (go) begin
      chk("mem_ready", mem_ready, mdl_ready());
      chk("dmem_req", bus.dmem_req, reqing);
      if (reqing) begin
        chk("dmem_addr", bus.dmem_addr, {h.addr[15:1], 1'b0});
        chk("dmem_we", bus.dmem_we, h.op == OP_SW);
        chk("dmem_wdata", bus.dmem_wdata, h.data);
      end
      chk("fwd_valid", fwd_valid, hv && h.rw && h.op != OP_LW);
      if (hv && h.rw && h.op != OP_LW) begin
        chk("fwd_rd", fwd_rd, h.rd);
        chk("fwd_data", fwd_data, h.data);
      end
      chk("wb_valid", wb_valid, e_wbv);
      if (e_wbv) begin
        chk("wb_we", wb_we, e_wbwe);
        chk("wb_rd", wb_rd, e_rd);
        chk("wb_data", wb_data, e_data);
        chk("wb_halt", wb_halt, e_halt);
      end
      chk("mem_err", mem_err, err);
      if (wb_valid === 1'b1) begin
        lg.push_back('{wb_rd, wb_data, wb_we, wb_halt});
        lgc.push_back(cyc);
      end
      if (bus.dmem_req === 1'b1 && bus.dmem_addr == 16'h0020) to_req_cycles++;
      cyc++;
    end
  end

  // ---------------- stimulus
  function automatic ins_t mk(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] data,
                              input logic [3:0] rd, input logic rw, input int lat, input logic [15:0] rdata);
    ins_t i;
    i.op = op; i.addr = addr; i.data = data; i.rd = rd; i.rw = rw; i.lat = lat; i.rdata = rdata;
    return i;
  endfunction

  task automatic issue(input ins_t i);
    int n;
    cur = i;
    ex_valid = 1'b1; ex_opcode = i.op; ex_addr = i.addr; ex_data = i.data;
    ex_rd = i.rd; ex_regwrite = i.rw;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_acc && n < 100);
    if (!m_acc) begin
      n_total++;
      $display("FAIL accept_bound: op %0h not accepted within 100 cycles", i.op);
    end
  endtask

  ins_t tbl[8];
  wbe_t exp_wb[7];

  initial begin
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 16'h0000;
    cur = mk(OP_ADD, 0, 0, 0, 0, 0, 0);

    tbl[0] = mk(OP_ADD, 16'h0000, 16'h1234, 4'd3, 1'b1, 0, 16'h0000);
    tbl[1] = mk(OP_XOR, 16'h0000, 16'h00FF, 4'd4, 1'b1, 0, 16'h0000);
    tbl[2] = mk(OP_LW,  16'h0041, 16'h0000, 4'd5, 1'b1, 3, 16'hBEEF);
    tbl[3] = mk(OP_SW,  16'h0010, 16'hCAFE, 4'd0, 1'b0, 2, 16'h0000);
    tbl[4] = mk(OP_ADD, 16'h0000, 16'h0006, 4'd6, 1'b1, 0, 16'h0000);
    tbl[5] = mk(OP_LW,  16'h0020, 16'h0000, 4'd7, 1'b1, 0, 16'h0000);
    tbl[6] = mk(OP_ADD, 16'h0000, 16'h0088, 4'd8, 1'b1, 0, 16'h0000);
    tbl[7] = mk(OP_HLT, 16'h0000, 16'h0000, 4'd0, 1'b0, 0, 16'h0000);

    exp_wb[0] = '{4'd3, 16'h1234, 1'b1, 1'b0};
    exp_wb[1] = '{4'd4, 16'h00FF, 1'b1, 1'b0};
    exp_wb[2] = '{4'd5, 16'hBEEF, 1'b1, 1'b0};
    exp_wb[3] = '{4'd0, 16'hCAFE, 1'b0, 1'b0};
    exp_wb[4] = '{4'd6, 16'h0006, 1'b1, 1'b0};
    exp_wb[5] = '{4'd8, 16'h0088, 1'b1, 1'b0};
    exp_wb[6] = '{4'd0, 16'h0000, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    go = 1'b1;
    @(negedge clk);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_err", mem_err, 0);

    // Reset in the middle of an outstanding load
    issue(mk(OP_LW, 16'h0002, 16'h0000, 4'd9, 1'b1, 0, 16'h0000));
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("req_before_rst", bus.dmem_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_dmem_req", bus.dmem_req, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_mem_err", mem_err, 0);
    chk("midrst_mem_ready", mem_ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) issue(tbl[i]);
    ex_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    chk("wb_count", lg.size(), 7);
    if (lg.size() >= 7) begin
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("wb_log%0d_rd", i), lg[i].rd, exp_wb[i].rd);
        chk($sformatf("wb_log%0d_data", i), lg[i].d, exp_wb[i].d);
        chk($sformatf("wb_log%0d_we", i), lg[i].we, exp_wb[i].we);
        chk($sformatf("wb_log%0d_halt", i), lg[i].halt, exp_wb[i].halt);
      end
      chk("xor_follows_add", lgc[1], lgc[0] + 1);
    end
    chk("timeout_req_cycles", to_req_cycles, 4);
    chk("mem_err_sticky", mem_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
